// File: rtl/cbfp_buf_pkg.sv
// Shared definitions for the CBFP stage-2 output buffer and its controllers.
package cbfp_buf_pkg;

   localparam int unsigned CBFP_POPS_PER_FRAME = 16;
   localparam int unsigned CBFP_WORDS_PER_POP  = 32;

   typedef enum logic {
      BANK_EMPTY = 1'b0,
      BANK_FULL  = 1'b1
   } bank_state_e;

endpackage

// File: rtl/cbfp_mod_cnt.sv
// Modulo-N counter with enable, synchronous clear and terminal-count flag.
// Wraps by explicit compare so non-power-of-2 moduli behave correctly.
module cbfp_mod_cnt #(
   parameter int unsigned N = 2,
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   logic [W-1:0] cnt_q, cnt_d;

   assign tc  = (cnt_q == W'(N - 1));
   assign cnt = cnt_q;

   // Advance on enable, wrapping to zero after the terminal value.
   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = tc ? '0 : cnt_q + W'(1);
      end
   end

   // Count register; reset dominates the soft clear.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cbfp_frame_bank_ctrl.sv
// Frame-fill controller: groups CBFP pops into frames, rotates through the
// buffer banks and tracks writer/reader ownership of each bank.
module cbfp_frame_bank_ctrl
   import cbfp_buf_pkg::*;
#(
   parameter int unsigned POPS_PER_FRAME = CBFP_POPS_PER_FRAME,
   parameter int unsigned NUM_BANKS      = 2,
   parameter int unsigned CNT_W          = $clog2(POPS_PER_FRAME),
   parameter int unsigned BANK_W         = $clog2(NUM_BANKS)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clr,
   input  logic              cbfp2_pop,
   input  logic              rd_done,
   output logic              in_ready,
   output logic [BANK_W-1:0] wr_bank,
   output logic [CNT_W-1:0]  wr_slot,
   output logic              frame_full,
   output logic [BANK_W-1:0] full_bank,
   output logic              rd_avail,
   output logic [BANK_W-1:0] rd_bank,
   output logic [BANK_W:0]   full_cnt,
   output logic              overflow
);

   localparam int unsigned FC_W = BANK_W + 1;

   bank_state_e       bank_q [NUM_BANKS];
   bank_state_e       bank_d [NUM_BANKS];
   logic [FC_W-1:0]   full_cnt_q, full_cnt_d;
   logic              frame_full_q;
   logic [BANK_W-1:0] full_bank_q;
   logic              overflow_q;

   logic accept, frame_done, do_release;
   logic slot_tc, wr_tc, rd_tc;
   logic tc_unused;

   assign accept     = cbfp2_pop & in_ready;
   assign frame_done = accept & slot_tc;
   assign do_release = rd_done & rd_avail;
   assign rd_avail   = (full_cnt_q != '0);
   assign tc_unused  = wr_tc ^ rd_tc;

   cbfp_mod_cnt #(.N(POPS_PER_FRAME), .W(CNT_W)) u_slot_cnt (
      .clk  (clk),
      .rstn (rstn),
      .clr  (clr),
      .en   (accept),
      .cnt  (wr_slot),
      .tc   (slot_tc)
   );

   cbfp_mod_cnt #(.N(NUM_BANKS), .W(BANK_W)) u_wr_bank_cnt (
      .clk  (clk),
      .rstn (rstn),
      .clr  (clr),
      .en   (frame_done),
      .cnt  (wr_bank),
      .tc   (wr_tc)
   );

   cbfp_mod_cnt #(.N(NUM_BANKS), .W(BANK_W)) u_rd_bank_cnt (
      .clk  (clk),
      .rstn (rstn),
      .clr  (clr),
      .en   (do_release),
      .cnt  (rd_bank),
      .tc   (rd_tc)
   );

   // Writer may proceed only while its target bank is still owned by it.
   always_comb begin
      in_ready = 1'b0;
      for (int i = 0; i < int'(NUM_BANKS); i++) begin
         if (wr_bank == BANK_W'(i)) in_ready = (bank_q[i] == BANK_EMPTY);
      end
   end

   // Completion hands wr_bank to the reader; release returns rd_bank.
   // The two never target the same bank in one cycle (EMPTY vs FULL).
   always_comb begin
      for (int i = 0; i < int'(NUM_BANKS); i++) begin
         bank_d[i] = bank_q[i];
         if (frame_done && wr_bank == BANK_W'(i)) bank_d[i] = BANK_FULL;
         if (do_release && rd_bank == BANK_W'(i)) bank_d[i] = BANK_EMPTY;
      end
   end

   // Occupancy: +1 on completion, -1 on release, net zero when both occur.
   always_comb begin
      full_cnt_d = full_cnt_q;
      if (frame_done && !do_release) full_cnt_d = full_cnt_q + FC_W'(1);
      if (!frame_done && do_release) full_cnt_d = full_cnt_q - FC_W'(1);
   end

   // Bank state, occupancy, frame pulse and sticky overflow registers.
   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         for (int i = 0; i < int'(NUM_BANKS); i++) bank_q[i] <= BANK_EMPTY;
         full_cnt_q   <= '0;
         frame_full_q <= 1'b0;
         full_bank_q  <= '0;
         overflow_q   <= 1'b0;
      end else begin
         for (int i = 0; i < int'(NUM_BANKS); i++) bank_q[i] <= bank_d[i];
         full_cnt_q   <= full_cnt_d;
         frame_full_q <= frame_done;
         if (frame_done) full_bank_q <= wr_bank;
         overflow_q   <= overflow_q | (cbfp2_pop & ~in_ready);
      end
   end

   assign full_cnt   = full_cnt_q;
   assign frame_full = frame_full_q;
   assign full_bank  = full_bank_q;
   assign overflow   = overflow_q;

   // Occupancy stays within [0, NUM_BANKS].
   a_cnt_max : assert property (@(posedge clk) disable iff (!rstn)
      full_cnt_q <= FC_W'(NUM_BANKS));
   a_cnt_min : assert property (@(posedge clk) disable iff (!rstn)
      !(do_release && !frame_done && full_cnt_q == '0));

endmodule

// File: tb/tb_cbfp_frame_bank_ctrl.sv
// Bench for cbfp_frame_bank_ctrl: two instances (2 banks x 16 pops and
// 3 banks x 4 pops) checked every cycle against a queue-based bank model.
module tb_cbfp_frame_bank_ctrl;

   logic clk, rstn;
   logic pop [2];
   logic rd  [2];
   logic clr [2];

   logic       a_ir, a_ff, a_ra, a_ovf;
   logic [0:0] a_wb, a_fb, a_rb;
   logic [3:0] a_ws;
   logic [1:0] a_fc;

   logic       b_ir, b_ff, b_ra, b_ovf;
   logic [1:0] b_wb, b_fb, b_rb;
   logic [1:0] b_ws;
   logic [2:0] b_fc;

   cbfp_frame_bank_ctrl #(.POPS_PER_FRAME(16), .NUM_BANKS(2)) u_dut_a (
      .clk(clk), .rstn(rstn), .clr(clr[0]), .cbfp2_pop(pop[0]), .rd_done(rd[0]),
      .in_ready(a_ir), .wr_bank(a_wb), .wr_slot(a_ws), .frame_full(a_ff),
      .full_bank(a_fb), .rd_avail(a_ra), .rd_bank(a_rb), .full_cnt(a_fc), .overflow(a_ovf)
   );

   cbfp_frame_bank_ctrl #(.POPS_PER_FRAME(4), .NUM_BANKS(3)) u_dut_b (
      .clk(clk), .rstn(rstn), .clr(clr[1]), .cbfp2_pop(pop[1]), .rd_done(rd[1]),
      .in_ready(b_ir), .wr_bank(b_wb), .wr_slot(b_ws), .frame_full(b_ff),
      .full_bank(b_fb), .rd_avail(b_ra), .rd_bank(b_rb), .full_cnt(b_fc), .overflow(b_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: FIFO of FULL bank indices plus writer position.
   int P [2] = '{16, 4};
   int N [2] = '{2, 3};
   int m_wr [2], m_slot [2], m_ff [2], m_fb [2], m_rd [2], m_ovf [2];
   int fq [2][$];

   function automatic bit in_q(int k, int b);
      foreach (fq[k][i]) if (fq[k][i] == b) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_edge(int k);
      bit ready, rel;
      int b;
      if (!rstn || clr[k]) begin
         m_wr[k] = 0; m_slot[k] = 0; m_ff[k] = 0; m_fb[k] = 0; m_rd[k] = 0; m_ovf[k] = 0;
         fq[k].delete();
         return;
      end
      ready = !in_q(k, m_wr[k]);
      rel   = rd[k] && (fq[k].size() > 0);
      m_ff[k] = 0;
      if (rel) begin
         b = fq[k].pop_front();
         m_rd[k] = (b + 1) % N[k];
      end
      if (pop[k] && ready) begin
         if (m_slot[k] == P[k] - 1) begin
            m_slot[k] = 0;
            fq[k].push_back(m_wr[k]);
            m_ff[k] = 1;
            m_fb[k] = m_wr[k];
            m_wr[k] = (m_wr[k] + 1) % N[k];
         end else begin
            m_slot[k]++;
         end
      end
      if (pop[k] && !ready) m_ovf[k] = 1;
   endtask

   task automatic cmp(string tag, int k, int obs, int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s dut%0d: got %0d want %0d", tag, k, obs, exp);
      end
   endtask

   task automatic chk(int k);
      int o [9];
      int exp_rb;
      if (k == 0) o = '{int'(a_ir), int'(a_wb), int'(a_ws), int'(a_ff), int'(a_fb),
                        int'(a_ra), int'(a_rb), int'(a_fc), int'(a_ovf)};
      else        o = '{int'(b_ir), int'(b_wb), int'(b_ws), int'(b_ff), int'(b_fb),
                        int'(b_ra), int'(b_rb), int'(b_fc), int'(b_ovf)};
      exp_rb = (fq[k].size() > 0) ? fq[k][0] : m_rd[k];
      cmp("in_ready",   k, o[0], int'(!in_q(k, m_wr[k])));
      cmp("wr_bank",    k, o[1], m_wr[k]);
      cmp("wr_slot",    k, o[2], m_slot[k]);
      cmp("frame_full", k, o[3], m_ff[k]);
      if (m_ff[k] != 0) cmp("full_bank", k, o[4], m_fb[k]);
      cmp("rd_avail",   k, o[5], int'(fq[k].size() > 0));
      cmp("rd_bank",    k, o[6], exp_rb);
      cmp("full_cnt",   k, o[7], fq[k].size());
      cmp("overflow",   k, o[8], m_ovf[k]);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      chk(0);
      chk(1);
   endtask

   task automatic idle();
      for (int k = 0; k < 2; k++) begin
         pop[k] = 1'b0; rd[k] = 1'b0; clr[k] = 1'b0;
      end
   endtask

   task automatic pops(int k, int n);
      pop[k] = 1'b1;
      repeat (n) cyc();
      pop[k] = 1'b0;
   endtask

   initial begin
      rstn = 1'b0;
      idle();
      repeat (2) cyc();
      rstn = 1'b1;
      cyc();

      // First frame into bank 0, then idle to see the one-cycle pulse end.
      pops(0, 16);
      cyc();

      // Bank 1 completes in the same cycle bank 0 is released.
      pops(0, 15);
      pop[0] = 1'b1; rd[0] = 1'b1;
      cyc();
      idle();
      cyc();

      // Fill bank 0 too, then a rejected pop, then a release.
      pops(0, 16);
      pops(0, 1);
      rd[0] = 1'b1;
      cyc();
      cyc();
      idle();
      // Spurious releases with nothing FULL.
      rd[0] = 1'b1;
      repeat (2) cyc();
      idle();
      cyc();

      // Abort mid-frame with clr, then a clean frame.
      pops(0, 7);
      clr[0] = 1'b1;
      cyc();
      clr[0] = 1'b0;
      pops(0, 16);
      cyc();

      // Same abort with rstn.
      pops(0, 7);
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      pops(0, 16);
      cyc();

      // Three banks of four: 12 pops with interleaved releases.
      rd[0] = 1'b1;
      cyc();
      idle();
      for (int i = 0; i < 12; i++) begin
         pop[1] = 1'b1;
         rd[1]  = (i % 4 == 1);
         cyc();
      end
      idle();
      rd[1] = 1'b1;
      repeat (4) cyc();
      idle();
      cyc();

      // Random traffic on both instances.
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < 2; k++) begin
            pop[k] = ($urandom_range(0, 3) != 0);
            rd[k]  = ($urandom_range(0, 2) == 0);
            clr[k] = ($urandom_range(0, 79) == 0);
         end
         cyc();
      end
      idle();
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
